// File: rtl/video_pkg.sv
// Shared video types and constants: RGB888 pixel, black, default transparency key, sync idle level.
package video_pkg;

    typedef logic [23:0] rgb888_t;

    localparam rgb888_t BLACK             = 24'h000000;
    localparam rgb888_t DEFAULT_KEY_COLOR = 24'hFFFFFF;
    localparam logic    SYNC_IDLE         = 1'b1;

endpackage

// File: rtl/blink_timer.sv
// Frame counter that toggles blink_phase every BLINK_FRAMES frame_start pulses.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    output logic blink_phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage layer compositor: register inputs, then pick the lowest-index eligible layer.
// Optional per-layer blinking is built when COMPOSITOR_BLINK_EN is defined.
module pixel_compositor
    import video_pkg::*;
#(
    parameter int                    NUM_LAYERS   = 4,
    parameter int                    DATA_WIDTH   = 24,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR    = DATA_WIDTH'(DEFAULT_KEY_COLOR),
    parameter int                    BLINK_FRAMES = 30,
    localparam int                   LW           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bright_in,
    input  logic                             hsync_in,
    input  logic                             vsync_in,
    input  logic                             frame_start,
    input  logic [NUM_LAYERS-1:0]            pix_en,
    input  logic [NUM_LAYERS*DATA_WIDTH-1:0] pixels,
    input  logic [DATA_WIDTH-1:0]            bg_color,
    input  logic [NUM_LAYERS-1:0]            blink_mask,
    output logic [DATA_WIDTH-1:0]            rgb,
    output logic                             bright_out,
    output logic                             hsync_out,
    output logic                             vsync_out,
    output logic                             hit_valid,
    output logic [LW-1:0]                    hit_layer
);

    logic [NUM_LAYERS*DATA_WIDTH-1:0] s1_pixels;
    logic [NUM_LAYERS-1:0]            s1_pix_en;
    logic [NUM_LAYERS-1:0]            s1_blink_mask;
    logic [DATA_WIDTH-1:0]            s1_bg_color;
    logic                             s1_bright;
    logic                             s1_hsync;
    logic                             s1_vsync;
    logic                             blink_phase;

`ifdef COMPOSITOR_BLINK_EN
    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .blink_phase(blink_phase)
    );
`else
    // Phase tied low makes the mask gating a no-op; frame_start has no consumer.
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign blink_phase        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_pixels     <= '0;
            s1_pix_en     <= '0;
            s1_blink_mask <= '0;
            s1_bg_color   <= '0;
            s1_bright     <= 1'b0;
            s1_hsync      <= SYNC_IDLE;
            s1_vsync      <= SYNC_IDLE;
        end else begin
            s1_pixels     <= pixels;
            s1_pix_en     <= pix_en;
            s1_blink_mask <= blink_mask;
            s1_bg_color   <= bg_color;
            s1_bright     <= bright_in;
            s1_hsync      <= hsync_in;
            s1_vsync      <= vsync_in;
        end
    end

    logic                  sel_hit;
    logic [LW-1:0]         sel_idx;
    logic [DATA_WIDTH-1:0] sel_pix;

    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        sel_pix = s1_bg_color;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!sel_hit && s1_pix_en[i]
                && (s1_pixels[i*DATA_WIDTH +: DATA_WIDTH] != KEY_COLOR)
                && !(blink_phase && s1_blink_mask[i])) begin
                sel_hit = 1'b1;
                sel_idx = LW'(i);
                sel_pix = s1_pixels[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb        <= '0;
            hit_valid  <= 1'b0;
            hit_layer  <= '0;
            bright_out <= 1'b0;
            hsync_out  <= SYNC_IDLE;
            vsync_out  <= SYNC_IDLE;
        end else begin
            bright_out <= s1_bright;
            hsync_out  <= s1_hsync;
            vsync_out  <= s1_vsync;
            if (!s1_bright) begin
                rgb       <= DATA_WIDTH'(BLACK);
                hit_valid <= 1'b0;
                hit_layer <= '0;
            end else begin
                rgb       <= sel_pix;
                hit_valid <= sel_hit;
                hit_layer <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed self-checking bench for pixel_compositor; blink expectations follow COMPOSITOR_BLINK_EN.
module tb_pixel_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        bright_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        frame_start;
    logic [3:0]  pix_en;
    logic [95:0] pixels;
    logic [23:0] bg_color;
    logic [3:0]  blink_mask;
    logic [23:0] rgb;
    logic        bright_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hit_valid;
    logic [1:0]  hit_layer;

    int compared = 0;
    int mismatched = 0;

`ifdef COMPOSITOR_BLINK_EN
    localparam logic [23:0] BLINKED_RGB = 24'h00FF00;
`else
    localparam logic [23:0] BLINKED_RGB = 24'hFF0000;
`endif

    pixel_compositor #(
        .NUM_LAYERS  (4),
        .DATA_WIDTH  (24),
        .KEY_COLOR   (24'hFFFFFF),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bright_in  (bright_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .frame_start(frame_start),
        .pix_en     (pix_en),
        .pixels     (pixels),
        .bg_color   (bg_color),
        .blink_mask (blink_mask),
        .rgb        (rgb),
        .bright_out (bright_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hit_valid  (hit_valid),
        .hit_layer  (hit_layer)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; bright_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        frame_start = 1'b0; pix_en = '0; pixels = '0; bg_color = 24'h0000FF; blink_mask = '0;
        tick(2);
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_hsync", 32'(hsync_out), 32'h1);
        check("reset_vsync", 32'(vsync_out), 32'h1);
        check("reset_bright", 32'(bright_out), 32'h0);
        check("reset_hit", {29'h0, hit_valid, hit_layer}, 32'h0);

        // Priority: layers 1 and 2 valid, layer 1 wins.
        rst = 1'b0; bright_in = 1'b1;
        pix_en = 4'b0110; pixels = {24'h0, 24'h445566, 24'h112233, 24'h0};
        tick(1);
        check("latency_1cyc_rgb", 32'(rgb), 32'h0);
        tick(1);
        check("prio_rgb", 32'(rgb), 32'h112233);
        check("prio_layer", 32'(hit_layer), 32'h1);
        check("prio_valid", 32'(hit_valid), 32'h1);
        check("prio_bright", 32'(bright_out), 32'h1);

        // Mid-frame reset with active-low syncs in flight.
        hsync_in = 1'b0; vsync_in = 1'b0;
        tick(2);
        check("sync_low_h", 32'(hsync_out), 32'h0);
        check("sync_low_v", 32'(vsync_out), 32'h0);
        rst = 1'b1;
        tick(1);
        check("midrst_rgb", 32'(rgb), 32'h0);
        check("midrst_hsync", 32'(hsync_out), 32'h1);
        check("midrst_vsync", 32'(vsync_out), 32'h1);
        check("midrst_bright", 32'(bright_out), 32'h0);
        rst = 1'b0;
        tick(1);
        check("post_rst_1_rgb", 32'(rgb), 32'h0);
        check("post_rst_1_hsync", 32'(hsync_out), 32'h1);
        tick(1);
        check("post_rst_2_rgb", 32'(rgb), 32'h112233);
        check("post_rst_2_hsync", 32'(hsync_out), 32'h0);

        // Transparency key.
        hsync_in = 1'b1; vsync_in = 1'b1;
        pix_en = 4'b0011; pixels = {24'h0, 24'h0, 24'hABCDEF, 24'hFFFFFF};
        tick(2);
        check("key_rgb", 32'(rgb), 32'hABCDEF);
        check("key_layer", 32'(hit_layer), 32'h1);
        pixels = {24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF};
        tick(2);
        check("bg_rgb", 32'(rgb), 32'h0000FF);
        check("bg_hit", {29'h0, hit_valid, hit_layer}, 32'h0);

        // Lowest-priority layer alone.
        pix_en = 4'b1000; pixels = {24'h123456, 24'h0, 24'h0, 24'h0};
        tick(2);
        check("l3_rgb", 32'(rgb), 32'h123456);
        check("l3_hit", {29'h0, hit_valid, hit_layer}, 32'h7);

        // Blanking plus exact 2-cycle sync delay.
        bright_in = 1'b0; pix_en = 4'b1111;
        pixels = {24'h010101, 24'h020202, 24'h030303, 24'h040404};
        hsync_in = 1'b0;
        tick(1);
        check("blank_hsync_1", 32'(hsync_out), 32'h1);
        tick(1);
        check("blank_hsync_2", 32'(hsync_out), 32'h0);
        check("blank_rgb", 32'(rgb), 32'h0);
        check("blank_hit", {29'h0, hit_valid, hit_layer}, 32'h0);
        check("blank_bright", 32'(bright_out), 32'h0);

        // Blink with BLINK_FRAMES=2, layer 0 in the mask.
        hsync_in = 1'b1; bright_in = 1'b1; blink_mask = 4'b0001;
        pix_en = 4'b0011; pixels = {24'h0, 24'h0, 24'h00FF00, 24'hFF0000};
        tick(2);
        check("blink_pre", 32'(rgb), 32'hFF0000);
        for (int p = 0; p < 2; p++) begin
            frame_start = 1'b1; tick(1);
            frame_start = 1'b0; tick(1);
        end
        check("blink_on", 32'(rgb), 32'(BLINKED_RGB));
        for (int p = 0; p < 2; p++) begin
            frame_start = 1'b1; tick(1);
            frame_start = 1'b0; tick(1);
        end
        check("blink_off", 32'(rgb), 32'hFF0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pixel_compositor.md
# pixel_compositor

Registered, parametrised multi-layer pixel compositor between the sprite/tile fetch logic and the VGA DAC pins. Each cycle it takes NUM_LAYERS candidate pixels with per-layer valid flags and picks the highest-priority non-transparent one. It falls back to a background colour and forces black outside the visible region. Sync and blanking sideband are delayed to match the pipeline, and optional per-layer blinking is driven by a frame counter.

## Interface
- NUM_LAYERS, 4: number of pixel layers; layer 0 has highest priority.
- DATA_WIDTH, 24: bits per pixel (RGB888 at 24).
- KEY_COLOR, 24'hFFFFFF: transparency key; a layer pixel equal to it is treated as absent.
- BLINK_FRAMES, 30: frames per blink half-period (≥1); used only with blink compiled in.
- clk  input  1  pixel clock.
- rst  input  1  synchronous, active-high reset.
- bright_in  input  1  visible-region flag from the VGA timing generator.
- hsync_in, vsync_in  input  1 each  active-low syncs from the timing generator.
- frame_start  input  1  one-cycle pulse per frame; used by the blink counter.
- pix_en  input  NUM_LAYERS  per-layer pixel-valid flags.
- pixels  input  NUM_LAYERS*DATA_WIDTH  layer pixels packed; layer i is at [i*DATA_WIDTH +: DATA_WIDTH].
- bg_color  input  DATA_WIDTH  background colour.
- blink_mask  input  NUM_LAYERS  layers that take part in blinking.
- rgb  output  DATA_WIDTH  composited colour to the DAC.
- bright_out, hsync_out, vsync_out  output  1 each  sideband delayed to align with rgb.
- hit_valid  output  1  a layer supplied rgb this cycle.
- hit_layer  output  $clog2(NUM_LAYERS) (min 1)  index of the winning layer; 0 when hit_valid=0.

## Operation
- Stage 1 registers all inputs: pixels, pix_en, bg_color, blink_mask, bright_in, hsync_in, vsync_in.
- A layer is eligible when all of these hold:
  - its registered pix_en bit is 1;
  - its pixel ≠ KEY_COLOR;
  - it is not blanked by blink.
- Stage 2 takes the lowest-index eligible layer.
- Stage 2 registered outputs:
  - bright=0: rgb=0, hit_valid=0, hit_layer=0, whatever the layers hold.
  - bright=1 and a layer is eligible: rgb = that layer's pixel, hit_valid=1, hit_layer = its index.
  - bright=1 and no layer is eligible: rgb = bg_color, hit_valid=0, hit_layer=0.
- The sideband is passed through both stages unchanged.
- Blink:
  - A frame counter (0..BLINK_FRAMES-1) increments on each frame_start.
  - When it wraps to 0, blink_phase toggles.
  - While blink_phase=1, layers with their blink_mask bit set are not eligible.
  - With BLINK_FRAMES=1, blink_phase toggles on every frame_start.
- Reset values:
  - rgb=0, hit_valid=0, hit_layer=0, bright_out=0;
  - hsync_out=1, vsync_out=1;
  - all stage-1 registers use the same idle values;
  - frame counter=0, blink_phase=0.

## Timing
- Latency is 2 cycles from inputs to rgb/sideband; throughput is one pixel per cycle with no stalls.
- Inputs sampled at edge N appear on the outputs after edge N+1.
- rst has priority over every other input. rst asserted mid-frame flushes the pipeline: outputs hold reset values from the first edge with rst=1. The first real pixel appears 2 edges after rst deasserts.
- A frame_start arriving in the same cycle as rst is ignored.
- blink_phase updates on the edge that samples frame_start. It applies to pixels that stage 2 evaluates from the next cycle on.
- Changes to blink_mask and bg_color follow the same 2-cycle alignment as the pixels.

## Configuration
- COMPOSITOR_BLINK_EN defined: frame counter, blink_phase and blink_mask gating are present as described.
- COMPOSITOR_BLINK_EN undefined:
  - no counter is built;
  - frame_start and blink_mask are ignored;
  - every layer is eligible on pix_en and key alone;
  - ports remain the same.

## Structure
- Shared package `video_pkg` holds:
  - the RGB888 pixel typedef;
  - the BLACK (24'h000000) and default KEY_COLOR constants;
  - the sync idle level (1'b1).
- Sub-module `blink_timer` holds the frame counter and blink_phase logic (instantiated only under COMPOSITOR_BLINK_EN).
- The priority encoder stays inline.

## Test plan
- Reset mid-frame: drive pixels, assert rst for 1 cycle → next edge rgb=0, hsync_out=vsync_out=1, bright_out=0; valid output resumes 2 cycles after release.
- Priority: NUM_LAYERS=4, bright=1, pix_en=4'b0110, layer1=24'h112233, layer2=24'h445566 → after 2 cycles rgb=24'h112233, hit_layer=1, hit_valid=1.
- Transparency: pix_en=4'b0011, layer0=24'hFFFFFF, layer1=24'hABCDEF → rgb=24'hABCDEF, hit_layer=1; set layer1=24'hFFFFFF too → rgb=bg_color (24'h0000FF), hit_valid=0.
- Blanking: bright_in=0 with pix_en=4'b1111 → rgb=0, hit_valid=0; syncs arrive delayed exactly 2 cycles.
- Blink (macro on, BLINK_FRAMES=2):
  - setup: blink_mask=4'b0001, layer0=24'hFF0000, layer1=24'h00FF00, both enabled;
  - 2 frame_start pulses → rgb=24'h00FF00;
  - 2 more → rgb=24'hFF0000.
- Blink (macro off): same stimulus → rgb stays 24'hFF0000 throughout.
